// File: rtl/alu_pkg.sv
// alu_pkg: ALU func codes, MIPS opcode/funct constants and dispatcher state enum
package alu_pkg;
  localparam logic [5:0] F_ADD  = 6'h00;
  localparam logic [5:0] F_ADDU = 6'h01;
  localparam logic [5:0] F_SUB  = 6'h02;
  localparam logic [5:0] F_SUBU = 6'h03;
  localparam logic [5:0] F_MUL  = 6'h04;
  localparam logic [5:0] F_MULU = 6'h05;
  localparam logic [5:0] F_DIV  = 6'h06;
  localparam logic [5:0] F_DIVU = 6'h07;
  localparam logic [5:0] F_AND  = 6'h08;
  localparam logic [5:0] F_OR   = 6'h09;
  localparam logic [5:0] F_XOR  = 6'h10;
  localparam logic [5:0] F_NOR  = 6'h11;
  localparam logic [5:0] F_SLL  = 6'h12;
  localparam logic [5:0] F_SRA  = 6'h13;
  localparam logic [5:0] F_SRL  = 6'h14;
  localparam logic [5:0] F_IDLE = 6'h3F;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;
endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational MIPS instruction decode into ALU func, operands and destination
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] rs_val_i,
  input  logic [31:0] rt_val_i,
  output logic [5:0]  func_o,
  output logic [31:0] op_0_o,
  output logic [31:0] op_1_o,
  output logic [4:0]  dest_o,
  output logic        illegal_o,
  output logic        is_mul_o,
  output logic        is_div_o
);
  logic [5:0] opc, fn;
  logic [31:0] sext, zext, shamt;
  logic unused_rs;
  assign opc = instr_i[31:26];
  assign fn = instr_i[5:0];
  assign sext = {{16{instr_i[15]}}, instr_i[15:0]};
  assign zext = {16'b0, instr_i[15:0]};
  assign shamt = {27'b0, instr_i[10:6]};
  // rs arrives already read from the register file
  assign unused_rs = ^instr_i[25:21];
  always_comb begin
    func_o = F_IDLE;
    op_0_o = rs_val_i;
    op_1_o = rt_val_i;
    dest_o = instr_i[15:11];
    illegal_o = 1'b0;
    if (opc == OP_RTYPE) begin
      case (fn)
        FN_ADD:   func_o = F_ADD;
        FN_ADDU:  func_o = F_ADDU;
        FN_SUB:   func_o = F_SUB;
        FN_SUBU:  func_o = F_SUBU;
        FN_AND:   func_o = F_AND;
        FN_OR:    func_o = F_OR;
        FN_XOR:   func_o = F_XOR;
        FN_NOR:   func_o = F_NOR;
        FN_MULT:  func_o = F_MUL;
        FN_MULTU: func_o = F_MULU;
        FN_DIV:   func_o = F_DIV;
        FN_DIVU:  func_o = F_DIVU;
        FN_SLL:   begin func_o = F_SLL; op_0_o = rt_val_i; op_1_o = shamt; end
        FN_SRL:   begin func_o = F_SRL; op_0_o = rt_val_i; op_1_o = shamt; end
        FN_SRA:   begin func_o = F_SRA; op_0_o = rt_val_i; op_1_o = shamt; end
        default:  illegal_o = 1'b1;
      endcase
    end else begin
      dest_o = instr_i[20:16];
      case (opc)
        OP_ADDI:  begin func_o = F_ADD;  op_1_o = sext; end
        OP_ADDIU: begin func_o = F_ADDU; op_1_o = sext; end
        OP_ANDI:  begin func_o = F_AND;  op_1_o = zext; end
        OP_ORI:   begin func_o = F_OR;   op_1_o = zext; end
        OP_XORI:  begin func_o = F_XOR;  op_1_o = zext; end
        default:  illegal_o = 1'b1;
      endcase
    end
  end
  assign is_mul_o = (func_o == F_MUL) | (func_o == F_MULU);
  assign is_div_o = (func_o == F_DIV) | (func_o == F_DIVU);
endmodule

// File: rtl/alu_dispatch.sv
// alu_dispatch: drives the ALU for the op latency and returns its result over valid/ready; ALU_DISPATCH_PERF_EN adds perf counters
module alu_dispatch
  import alu_pkg::*;
#(
  parameter int MUL_LAT    = 2,
  parameter int DIV_LAT    = 8,
  parameter int SIMPLE_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [5:0]  alu_func,
  output logic [31:0] alu_op_0,
  output logic [31:0] alu_op_1,
  input  logic [31:0] alu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_illegal,
  output logic        out_div0
`ifdef ALU_DISPATCH_PERF_EN
  ,
  output logic [31:0] perf_ops,
  output logic [31:0] perf_stall
`endif
);
  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? ((DIV_LAT > SIMPLE_LAT) ? DIV_LAT : SIMPLE_LAT)
                                               : ((MUL_LAT > SIMPLE_LAT) ? MUL_LAT : SIMPLE_LAT);
  localparam int CW = $clog2(MAX_LAT + 1);
  state_e state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0] func_q;
  logic [31:0] op_0_q, op_1_q, result_q;
  logic [4:0] rd_q;
  logic illegal_q, div0_q, accept;
  logic [5:0] dec_func;
  logic [31:0] dec_op_0, dec_op_1;
  logic [4:0] dec_dest;
  logic dec_illegal, dec_is_mul, dec_is_div;
  alu_decode u_decode (
    .instr_i   (instr),
    .rs_val_i  (rs_val),
    .rt_val_i  (rt_val),
    .func_o    (dec_func),
    .op_0_o    (dec_op_0),
    .op_1_o    (dec_op_1),
    .dest_o    (dec_dest),
    .illegal_o (dec_illegal),
    .is_mul_o  (dec_is_mul),
    .is_div_o  (dec_is_div)
  );
  assign in_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept = in_valid & in_ready;
  assign cnt_d = dec_is_div ? CW'(DIV_LAT - 1) : dec_is_mul ? CW'(MUL_LAT - 1) : CW'(SIMPLE_LAT - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      func_q <= F_IDLE;
      op_0_q <= '0;
      op_1_q <= '0;
      result_q <= '0;
      rd_q <= '0;
      illegal_q <= 1'b0;
      div0_q <= 1'b0;
    end else if (accept) begin
      rd_q <= dec_dest;
      illegal_q <= dec_illegal;
      div0_q <= dec_is_div & (rt_val == '0);
      if (dec_illegal) begin
        state_q <= S_DONE;
        result_q <= '0;
      end else begin
        state_q <= S_EXEC;
        cnt_q <= cnt_d;
        func_q <= dec_func;
        op_0_q <= dec_op_0;
        op_1_q <= dec_op_1;
      end
    end else if (state_q == S_EXEC) begin
      if (cnt_q == '0) begin
        state_q <= S_DONE;
        result_q <= alu_result;
        func_q <= F_IDLE;
        op_0_q <= '0;
        op_1_q <= '0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end else if ((state_q == S_DONE) & out_ready) begin
      state_q <= S_IDLE;
    end
  end
  assign alu_func = func_q;
  assign alu_op_0 = op_0_q;
  assign alu_op_1 = op_1_q;
  assign out_valid = (state_q == S_DONE);
  assign out_result = result_q;
  assign out_rd = rd_q;
  assign out_illegal = illegal_q;
  assign out_div0 = div0_q;
`ifdef ALU_DISPATCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ops <= '0;
      perf_stall <= '0;
    end else begin
      perf_ops <= perf_ops + 32'(accept);
      perf_stall <= perf_stall + 32'(out_valid & ~out_ready);
    end
  end
`endif
endmodule

// File: tb/tb_alu_dispatch.sv
// tb_alu_dispatch: random + directed scoreboard bench with a behavioural ALU and MIPS reference model
module tb_alu_dispatch;
  localparam int MUL_LAT = 2, DIV_LAT = 8, SIMPLE_LAT = 1;
  localparam logic [5:0] RF [15] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                     6'h18, 6'h19, 6'h1A, 6'h1B, 6'h00, 6'h02, 6'h03};
  localparam logic [5:0] IOP [5] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E};
  logic clk = 0, rst = 1;
  logic in_valid, in_ready, out_valid, out_ready, out_illegal, out_div0;
  logic [31:0] instr, rs_val, rt_val, alu_op_0, alu_op_1, alu_result, out_result;
  logic [5:0] alu_func;
  logic [4:0] out_rd;
  typedef struct {logic [31:0] res; logic [4:0] rd; logic ill; logic d0; int vcyc;} out_t;
  typedef struct {logic [5:0] f; logic [31:0] a; logic [31:0] b; int lat;} ex_t;
  out_t oq[$];
  ex_t eq[$];
  int checks = 0, errors = 0, cyc = 0, mode = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  alu_dispatch #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .SIMPLE_LAT(SIMPLE_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rs_val(rs_val), .rt_val(rt_val), .alu_func(alu_func), .alu_op_0(alu_op_0),
    .alu_op_1(alu_op_1), .alu_result(alu_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_illegal(out_illegal), .out_div0(out_div0)
  );
  function automatic logic [31:0] alu_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      6'h00, 6'h01: return a + b;
      6'h02, 6'h03: return a - b;
      6'h04: return $signed(a) * $signed(b);
      6'h05: return a * b;
      6'h06: return (b == 0) ? 32'hFFFF_FFFF : $signed(a) / $signed(b);
      6'h07: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      6'h08: return a & b;
      6'h09: return a | b;
      6'h10: return a ^ b;
      6'h11: return ~(a | b);
      6'h12: return a << b[4:0];
      6'h13: return $signed(a) >>> b[4:0];
      6'h14: return a >> b[4:0];
      default: return 32'h0;
    endcase
  endfunction
  assign alu_result = alu_model(alu_func, alu_op_0, alu_op_1);
  function automatic void ref_model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                                    output logic ok, output logic [5:0] f, output logic [31:0] a,
                                    output logic [31:0] b, output int lat);
    logic [31:0] sh = {27'b0, ins[10:6]};
    logic [31:0] se = {{16{ins[15]}}, ins[15:0]};
    logic [31:0] ze = {16'b0, ins[15:0]};
    ok = 1; f = 6'h3F; a = rs; b = rt;
    if (ins[31:26] == 0) begin
      case (ins[5:0])
        6'h20: f = 6'h00; 6'h21: f = 6'h01; 6'h22: f = 6'h02; 6'h23: f = 6'h03;
        6'h24: f = 6'h08; 6'h25: f = 6'h09; 6'h26: f = 6'h10; 6'h27: f = 6'h11;
        6'h18: f = 6'h04; 6'h19: f = 6'h05; 6'h1A: f = 6'h06; 6'h1B: f = 6'h07;
        6'h00: begin f = 6'h12; a = rt; b = sh; end
        6'h02: begin f = 6'h14; a = rt; b = sh; end
        6'h03: begin f = 6'h13; a = rt; b = sh; end
        default: ok = 0;
      endcase
    end else begin
      case (ins[31:26])
        6'h08: begin f = 6'h00; b = se; end
        6'h09: begin f = 6'h01; b = se; end
        6'h0C: begin f = 6'h08; b = ze; end
        6'h0D: begin f = 6'h09; b = ze; end
        6'h0E: begin f = 6'h10; b = ze; end
        default: ok = 0;
      endcase
    end
    lat = (f == 6'h04 || f == 6'h05) ? MUL_LAT : (f == 6'h06 || f == 6'h07) ? DIV_LAT : SIMPLE_LAT;
  endfunction
  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] rand_instr();
    int k = $urandom_range(0, 21);
    logic [25:0] r = 26'($urandom);
    if (k < 15) return {6'h00, r[25:6], RF[k]};
    if (k < 20) return {IOP[k-15], r};
    if (k == 20) return {6'h3F, r};
    return {6'h00, r[25:6], 6'h01};
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", n, act, exp, cyc);
    end
  endtask
  task automatic issue(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    logic ok;
    logic [5:0] f;
    logic [31:0] a, b;
    int lat, t;
    @(posedge clk);
    #1;
    in_valid = 1; instr = ins; rs_val = rs; rt_val = rt;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++t > 100) begin
        checks++; errors++;
        $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 100 cycles");
        return;
      end
    end
    ref_model(ins, rs, rt, ok, f, a, b, lat);
    oq.push_back('{ok ? alu_model(f, a, b) : 32'h0, (ins[31:26] == 0) ? ins[15:11] : ins[20:16],
                   !ok, ok && (f == 6'h06 || f == 6'h07) && rt == 0, cyc + 1 + (ok ? lat : 0)});
    if (ok) eq.push_back('{f, a, b, lat});
  endtask
  task automatic idle(input int n);
    @(posedge clk);
    #1 in_valid = 0;
    repeat (n) @(posedge clk);
  endtask
  task automatic ready_drv();
    forever begin
      @(posedge clk);
      #1 out_ready = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  endtask
  task automatic monitor();
    int run = 0;
    logic seen = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        run = 0; seen = 0;
      end else begin
        if (alu_func != 6'h3F) begin
          if (run == 0) begin
            if (eq.size() == 0) chk("alu_unexpected_func", 32'(alu_func), 32'h3F);
            else begin
              chk("alu_func", 32'(alu_func), 32'(eq[0].f));
              chk("alu_op_0", alu_op_0, eq[0].a);
              chk("alu_op_1", alu_op_1, eq[0].b);
            end
          end
          run++;
        end else begin
          chk("alu_idle_ops", alu_op_0 | alu_op_1, 32'h0);
          if (run > 0 && eq.size() > 0) begin
            chk("hold_len", 32'(run), 32'(eq[0].lat));
            void'(eq.pop_front());
          end
          run = 0;
        end
        if (out_valid) begin
          if (oq.size() == 0) chk("unexpected_valid", 32'(out_valid), 32'h0);
          else begin
            if (!seen) chk("valid_cycle", 32'(cyc), 32'(oq[0].vcyc));
            seen = 1;
            chk("out_result", out_result, oq[0].res);
            chk("out_illegal", 32'(out_illegal), 32'(oq[0].ill));
            chk("out_div0", 32'(out_div0), 32'(oq[0].d0));
            if (!oq[0].ill) chk("out_rd", 32'(out_rd), 32'(oq[0].rd));
            chk("in_ready_done", 32'(in_ready), 32'(out_ready));
            if (out_ready) begin
              void'(oq.pop_front());
              seen = 0;
            end
          end
        end
      end
    end
  endtask
  initial begin
    int t;
    in_valid = 0; instr = 0; rs_val = 0; rt_val = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_result", out_result, 32'h0);
    chk("rst_out_rd", 32'(out_rd), 32'h0);
    chk("rst_out_illegal", 32'(out_illegal), 32'h0);
    chk("rst_out_div0", 32'(out_div0), 32'h0);
    chk("rst_alu_func", 32'(alu_func), 32'h3F);
    chk("rst_alu_ops", alu_op_0 | alu_op_1, 32'h0);
    rst = 0;
    fork
      monitor();
      ready_drv();
    join_none
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    mode = 1;
    issue(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd5, 32'd7);
    issue(itype(6'h08, 5'd1, 5'd9, 16'hFFFF), 32'd1, 32'd0);
    issue(itype(6'h0D, 5'd2, 5'd10, 16'h8000), 32'h1234_0000, 32'd0);
    issue(rtype(5'd0, 5'd4, 5'd11, 5'd4, 6'h03), 32'd0, 32'h8000_0000);
    idle(2);
    mode = 2;
    issue(rtype(5'd4, 5'd5, 5'd6, 5'd0, 6'h1A), 32'd100, 32'd0);
    idle(12);
    mode = 1;
    issue(itype(6'h3F, 5'd1, 5'd2, 16'h1234), 32'd1, 32'd2);
    issue(rtype(5'd1, 5'd2, 5'd7, 5'd0, 6'h01), 32'd1, 32'd2);
    issue(rtype(5'd1, 5'd2, 5'd8, 5'd0, 6'h18), 32'hFFFF_FFFD, 32'd7);
    idle(3);
    mode = 0;
    for (int i = 0; i < 120; i++) begin
      issue(rand_instr(), $urandom, ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
    end
    idle(1);
    mode = 1;
    t = 0;
    while ((oq.size() != 0 || eq.size() != 0) && t < 500) begin
      @(posedge clk);
      t++;
    end
    issue(rtype(5'd4, 5'd5, 5'd6, 5'd0, 6'h1A), 32'd50, 32'd5);
    idle(3);
    #1 rst = 1;
    oq.delete();
    eq.delete();
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_alu_func", 32'(alu_func), 32'h3F);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);
    chk("post_rst_out_valid", 32'(out_valid), 32'h0);
    issue(rtype(5'd1, 5'd2, 5'd12, 5'd0, 6'h22), 32'd20, 32'd8);
    idle(1);
    t = 0;
    while ((oq.size() != 0 || eq.size() != 0) && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (oq.size() != 0 || eq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d results and %0d ALU ops outstanding, required 0", oq.size(), eq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
